// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA 640x480@60 timing generator with pixel gating (optional VGA_BORDER_EN frame border)
module vga_sync_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned H_VIS    = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned V_VIS    = 480,
    parameter int unsigned V_FP     = 10,
    parameter logic [2:0]  FG_COLOR = 3'b111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pixel_in,
    output logic [9:0] HCounter,
    output logic [9:0] VCounter,
    output logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       frame_tick,
    output logic [2:0] rgb
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_VIS + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_VIS + V_FP;

    // A divide-by-one still needs a one-bit register so the declaration stays legal.
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
    localparam logic [9:0] H_VIS_START = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_VIS_END   = 10'(H_SYNC + H_BP + H_VIS);
    localparam logic [9:0] V_VIS_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_VIS_END   = 10'(V_SYNC + V_BP + V_VIS);

    logic [DIV_W-1:0] div;
    logic             h_last;
    logic             v_last;
    logic [2:0]       rgb_normal;

    assign h_last = (HCounter == H_LAST);
    assign v_last = (VCounter == V_LAST);

    // Pixel divider; pix_en is registered so it lands one clk after the divider hits its last count.
    always_ff @(posedge clk) begin
        if (reset) begin
            div    <= '0;
            pix_en <= 1'b0;
        end else begin
            pix_en <= (div == DIV_LAST);
            if (div == DIV_LAST)
                div <= '0;
            else
                div <= div + 1'b1;
        end
    end

    // Raster counters step once per pixel strobe; vertical only moves on a horizontal wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            HCounter <= '0;
            VCounter <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                HCounter <= '0;
                VCounter <= v_last ? 10'd0 : VCounter + 10'd1;
            end else begin
                HCounter <= HCounter + 10'd1;
            end
        end
    end

    // Frame tick fires only on the natural wrap to (0,0), never on a reset to (0,0).
    always_ff @(posedge clk) begin
        if (reset)
            frame_tick <= 1'b0;
        else
            frame_tick <= pix_en && h_last && v_last;
    end

    // Sync and visible-window decode straight off the counters, so no added latency.
    always_comb begin
        hsync      = (HCounter >= H_SYNC_END);
        vsync      = (VCounter >= V_SYNC_END);
        display_on = (HCounter >= H_VIS_START) && (HCounter < H_VIS_END) &&
                     (VCounter >= V_VIS_START) && (VCounter < V_VIS_END);
    end

    // Colour gating: object pixels only show inside the visible window.
    always_comb begin
        rgb_normal = (display_on && pixel_in) ? FG_COLOR : 3'b000;
`ifdef VGA_BORDER_EN
        if (display_on && ((HCounter == H_VIS_START) || (HCounter == H_VIS_END - 10'd1) ||
                           (VCounter == V_VIS_START) || (VCounter == V_VIS_END - 10'd1)))
            rgb = 3'b111;
        else
            rgb = rgb_normal;
`else
        rgb = rgb_normal;
`endif
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - randomized self-checking bench for vga_sync_gen against an arithmetic raster model
module tb_vga_sync_gen;

    localparam int D   = 2;
    localparam int HS  = 8;
    localparam int HBP = 6;
    localparam int HV  = 20;
    localparam int HFP = 4;
    localparam int VS  = 2;
    localparam int VBP = 3;
    localparam int VV  = 8;
    localparam int VFP = 2;
    localparam int HT  = HS + HBP + HV + HFP;
    localparam int VT  = VS + VBP + VV + VFP;
    localparam int FT  = HT * VT;
    localparam int HVS = HS + HBP;
    localparam int HVE = HS + HBP + HV;
    localparam int VVS = VS + VBP;
    localparam int VVE = VS + VBP + VV;
    localparam logic [2:0] FG  = 3'b110;
`ifdef VGA_BORDER_EN
    localparam logic [2:0] BRD = 3'b111;
`else
    localparam logic [2:0] BRD = 3'b000;
`endif

    typedef struct {
        int         h;
        int         v;
        bit         pe;
        bit         ft;
        bit         hs;
        bit         vs;
        bit         de;
        logic [2:0] rgb;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pixel_in = 1'b0;
    logic [9:0] hc, vc, hc1, vc1;
    logic       pe, hs, vs, de, ft;
    logic       pe1, hs1, vs1, de1, ft1;
    logic [2:0] rgb, rgb1;

    int n = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Edges seen since reset was last sampled high; the whole model is derived from this.
    always @(posedge clk) n <= reset ? 0 : n + 1;

    vga_sync_gen #(.CLK_DIV(D), .H_SYNC(HS), .H_BP(HBP), .H_VIS(HV), .H_FP(HFP),
                   .V_SYNC(VS), .V_BP(VBP), .V_VIS(VV), .V_FP(VFP), .FG_COLOR(FG)) dut (
        .clk(clk), .reset(reset), .pixel_in(pixel_in), .HCounter(hc), .VCounter(vc),
        .pix_en(pe), .hsync(hs), .vsync(vs), .display_on(de), .frame_tick(ft), .rgb(rgb));

    vga_sync_gen #(.CLK_DIV(1), .H_SYNC(HS), .H_BP(HBP), .H_VIS(HV), .H_FP(HFP),
                   .V_SYNC(VS), .V_BP(VBP), .V_VIS(VV), .V_FP(VFP)) dut1 (
        .clk(clk), .reset(reset), .pixel_in(pixel_in), .HCounter(hc1), .VCounter(vc1),
        .pix_en(pe1), .hsync(hs1), .vsync(vs1), .display_on(de1), .frame_tick(ft1), .rgb(rgb1));

    // Position = number of pixel strobes consumed since reset, folded into the frame.
    function automatic exp_t model(int nn, int d, bit pin, logic [2:0] fg);
        exp_t e;
        int a, ap, p;
        a  = (nn < 1) ? 0 : (nn - 1) / d;
        ap = (nn < 2) ? 0 : (nn - 2) / d;
        p  = a % FT;
        e.h   = p % HT;
        e.v   = p / HT;
        e.pe  = (nn >= 1) && (nn % d == 0);
        e.ft  = (a != ap) && (p == 0);
        e.hs  = !(e.h < HS);
        e.vs  = !(e.v < VS);
        e.de  = (e.h >= HVS) && (e.h < HVE) && (e.v >= VVS) && (e.v < VVE);
        e.rgb = (e.de && pin) ? fg : 3'b000;
`ifdef VGA_BORDER_EN
        if (e.de && (e.h == HVS || e.h == HVE - 1 || e.v == VVS || e.v == VVE - 1))
            e.rgb = 3'b111;
`endif
        return e;
    endfunction

    task automatic wait_pos(input int x, input int y, output bit ok);
        exp_t e;
        ok = 0;
        for (int i = 0; i < 3 * FT * D; i++) begin
            @(negedge clk);
            e = model(n, D, pixel_in, FG);
            if (e.h == x && e.v == y) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pixel_in = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({hc, vc, pe, ft, hs, vs, de, rgb} !== 28'h0) begin
            errors++;
            $display("FAIL reset_state got h=%0d v=%0d pe=%b ft=%b hs=%b vs=%b de=%b rgb=%b want all zero",
                     hc, vc, pe, ft, hs, vs, de, rgb);
        end
        checks++;
        if ({hc1, vc1, pe1, ft1} !== 23'h0) begin
            errors++;
            $display("FAIL reset_state_div1 got h=%0d v=%0d pe=%b ft=%b want zero", hc1, vc1, pe1, ft1);
        end
    endtask

    task automatic test_divider();
        pixel_in = 1'b0;
        reset = 1'b0;
        for (int k = 1; k <= 2 * HT * D + 2; k++) begin
            @(negedge clk);
            if (k <= 8) begin
                checks++;
                if (pe !== ((k % D) == 0)) begin
                    errors++;
                    $display("FAIL pix_en_k%0d got %b want %b", k, pe, (k % D) == 0);
                end
                checks++;
                if (pe1 !== 1'b1) begin
                    errors++;
                    $display("FAIL pix_en_div1_k%0d got %b want 1", k, pe1);
                end
            end
            if (k == D + 1) begin
                checks++;
                if (hc !== 10'd1) begin
                    errors++;
                    $display("FAIL first_step got h=%0d want 1", hc);
                end
            end
            if (k == HT * D) begin
                checks++;
                if (hc !== 10'(HT - 1) || vc !== 10'd0) begin
                    errors++;
                    $display("FAIL pre_wrap got h=%0d v=%0d want %0d 0", hc, vc, HT - 1);
                end
            end
            if (k == HT * D + 1) begin
                checks++;
                if (hc !== 10'd0 || vc !== 10'd1) begin
                    errors++;
                    $display("FAIL line_wrap got h=%0d v=%0d want 0 1", hc, vc);
                end
            end
        end
    endtask

    task automatic run_random(input string tag, input int cycles);
        exp_t e, e1;
        int hlow, vlow, last_t, ticks;
        hlow = -1; vlow = -1; last_t = -1; ticks = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            pixel_in = 1'($urandom);
            #1;
            e  = model(n, D, pixel_in, FG);
            e1 = model(n, 1, pixel_in, 3'b111);
            checks++;
            if ({hc, vc, pe, ft, hs, vs, de, rgb} !==
                {10'(e.h), 10'(e.v), e.pe, e.ft, e.hs, e.vs, e.de, e.rgb}) begin
                errors++;
                $display("FAIL %s n=%0d got h=%0d v=%0d pe=%b ft=%b hs=%b vs=%b de=%b rgb=%b want h=%0d v=%0d pe=%b ft=%b hs=%b vs=%b de=%b rgb=%b",
                         tag, n, hc, vc, pe, ft, hs, vs, de, rgb, e.h, e.v, e.pe, e.ft, e.hs, e.vs, e.de, e.rgb);
            end
            checks++;
            if ({hc1, vc1, pe1, ft1, hs1, vs1, de1, rgb1} !==
                {10'(e1.h), 10'(e1.v), e1.pe, e1.ft, e1.hs, e1.vs, e1.de, e1.rgb}) begin
                errors++;
                $display("FAIL %s_div1 n=%0d got h=%0d v=%0d pe=%b ft=%b rgb=%b want h=%0d v=%0d pe=%b ft=%b rgb=%b",
                         tag, n, hc1, vc1, pe1, ft1, rgb1, e1.h, e1.v, e1.pe, e1.ft, e1.rgb);
            end
            if (hs === 1'b0) begin
                if (hlow >= 0) hlow++;
            end else begin
                if (hlow > 0) begin
                    checks++;
                    if (hlow != HS * D) begin
                        errors++;
                        $display("FAIL %s_hsync_width got %0d want %0d", tag, hlow, HS * D);
                    end
                end
                hlow = 0;
            end
            if (vs === 1'b0) begin
                if (vlow >= 0) vlow++;
            end else begin
                if (vlow > 0) begin
                    checks++;
                    if (vlow != VS * HT * D) begin
                        errors++;
                        $display("FAIL %s_vsync_width got %0d want %0d", tag, vlow, VS * HT * D);
                    end
                end
                vlow = 0;
            end
            if (ft === 1'b1) begin
                ticks++;
                if (last_t >= 0) begin
                    checks++;
                    if (n - last_t != FT * D) begin
                        errors++;
                        $display("FAIL %s_frame_period got %0d want %0d", tag, n - last_t, FT * D);
                    end
                end
                last_t = n;
            end
        end
        if (cycles > 2 * FT * D) begin
            checks++;
            if (ticks < 2) begin
                errors++;
                $display("FAIL %s_tick_count got %0d want >=2", tag, ticks);
            end
        end
    endtask

    task automatic test_free_run();
        run_random("free_run", 2 * FT * D + 120);
    endtask

    task automatic test_boundaries();
        int         px[8]   = '{HVS - 1, HVS, HVE - 1, HVE, 20, 20, HVS, HVS + 1};
        int         py[8]   = '{VVS, VVS, VVE - 1, VVE - 1, VVS - 1, VVE, 8, 8};
        bit         pde[8]  = '{0, 1, 1, 0, 0, 0, 1, 1};
        logic [2:0] prgb[8] = '{3'b000, BRD, BRD, 3'b000, 3'b000, 3'b000, BRD, 3'b000};
        bit         done[8] = '{default: 0};
        exp_t e;
        pixel_in = 1'b0;
        for (int i = 0; i < FT * D + 4; i++) begin
            @(negedge clk);
            #1;
            e = model(n, D, pixel_in, FG);
            for (int j = 0; j < 8; j++) begin
                if (!done[j] && e.h == px[j] && e.v == py[j]) begin
                    done[j] = 1;
                    checks++;
                    if (de !== pde[j] || rgb !== prgb[j]) begin
                        errors++;
                        $display("FAIL edge_%0d_%0d got de=%b rgb=%b want de=%b rgb=%b",
                                 px[j], py[j], de, rgb, pde[j], prgb[j]);
                    end
                end
            end
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (!done[j]) begin
                errors++;
                $display("FAIL edge_timeout_%0d got unvisited want visited", j);
            end
        end
    endtask

    task automatic test_pixel_gate();
        bit ok;
        pixel_in = 1'b1;
        wait_pos(4, 7, ok);
        #1;
        checks++;
        if (!ok || rgb !== 3'b000) begin
            errors++;
            $display("FAIL gate_outside got ok=%b rgb=%b want ok=1 rgb=000", ok, rgb);
        end
        wait_pos(20, 7, ok);
        #1;
        checks++;
        if (!ok || rgb !== FG) begin
            errors++;
            $display("FAIL gate_inside got ok=%b rgb=%b want ok=1 rgb=%b", ok, rgb, FG);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        pixel_in = 1'b0;
        wait_pos(20, 7, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL mid_reset_wait got timeout want position 20,7");
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({hc, vc, hs, vs, pe, ft, de} !== 27'h0) begin
            errors++;
            $display("FAIL mid_reset_state got h=%0d v=%0d hs=%b vs=%b pe=%b ft=%b de=%b want zeros",
                     hc, vc, hs, vs, pe, ft, de);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= D + 1; k++) begin
            @(negedge clk);
            checks++;
            if (pe !== (k == D) || ft !== 1'b0) begin
                errors++;
                $display("FAIL resume_pe_k%0d got pe=%b ft=%b want pe=%b ft=0", k, pe, ft, k == D);
            end
        end
        checks++;
        if (hc !== 10'd1 || vc !== 10'd0) begin
            errors++;
            $display("FAIL resume_count got h=%0d v=%0d want 1 0", hc, vc);
        end
    endtask

    task automatic test_back_to_back();
        run_random("back_to_back", 400);
    endtask

    initial begin
        test_reset();
        test_divider();
        test_free_run();
        test_boundaries();
        test_pixel_gate();
        test_reset_mid_frame();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Timing source for the 640x480@60 VGA path; drives HCounter/VCounter into every on-screen object block (square, asteroids, ship).
- Generates the pixel strobe, active-low hsync/vsync, the visible-area flag and a once-per-frame tick that object blocks use to step motion.
- Gates the objects' merged pixel bit into 3-bit RGB, forcing black outside the visible window.

Parameters:
- CLK_DIV, 2, system clocks per pixel (50 MHz -> 25 MHz); must be >= 1
- H_SYNC, 96, hsync pulse width in pixels
- H_BP, 48, horizontal back porch
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (H_TOTAL = 800)
- V_SYNC, 2, vsync pulse width in lines
- V_BP, 33, vertical back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch (V_TOTAL = 525)
- FG_COLOR, 3'b111, RGB driven when pixel_in is high in the visible area

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pixel_in  in  1  OR of all object result bits for the current HCounter/VCounter
- HCounter  out  10  horizontal pixel position, 0..H_TOTAL-1
- VCounter  out  10  vertical line position, 0..V_TOTAL-1
- pix_en  out  1  one-clk strobe; the counters advance on clk edges where it is high
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- display_on  out  1  high inside the visible window
- frame_tick  out  1  one-clk pulse at the start of each frame
- rgb  out  3  {r,g,b} pixel colour

Behaviour:
Clock and reset:
- All state changes on posedge clk.
- reset is synchronous, active-high; it is sampled every clk edge regardless of pix_en.
- Reset values: divider=0, HCounter=0, VCounter=0, pix_en=0, frame_tick=0.
- Decoded outputs while in reset: hsync=0, vsync=0, display_on=0, rgb=0.

Pixel divider:
- Counts 0..CLK_DIV-1 and wraps.
- pix_en is registered: high for exactly one clk each time the divider reaches CLK_DIV-1.
- With CLK_DIV=1, pix_en is held high continuously once reset is released.

Counters (advance only on edges where pix_en=1):
- HCounter += 1; at H_TOTAL-1 it wraps to 0 instead.
- VCounter changes only on an HCounter wrap: +1, or 0 when it is at V_TOTAL-1.
- No other values are ever reachable; there is no overflow path.

Decode:
- Combinational from the registered counters, so zero latency relative to HCounter/VCounter.
- hsync = !(HCounter < H_SYNC).
- vsync = !(VCounter < V_SYNC).
- display_on = (H_SYNC+H_BP <= HCounter < H_SYNC+H_BP+H_VIS) && (V_SYNC+V_BP <= VCounter < V_SYNC+V_BP+V_VIS).
- With defaults the visible window is H 144..783, V 35..514.

frame_tick:
- Registered; asserted on the clk edge where both counters wrap to 0.
- Therefore it is high for exactly one clk during the first cycle of (0,0), then drops even though the counters stay at (0,0) for CLK_DIV clks.
- It is not asserted when reset forces (0,0).

rgb:
- Combinational: FG_COLOR when display_on && pixel_in, else 3'b000.
- pixel_in outside the visible window is ignored.

Boundary conditions:
- Reset mid-frame: the next edge returns all state to reset values; the first pix_en then arrives CLK_DIV clks after reset deasserts.

Optional Feature:
- Macro: VGA_BORDER_EN.
- Defined: rgb = 3'b111 on the outermost visible column and row (HCounter 144 or 783, VCounter 35 or 514) regardless of pixel_in; elsewhere rgb follows the normal rule.
- Undefined: no border logic is compiled in; rgb follows the normal rule everywhere.

Test Plan:
- Reset, then CLK_DIV=2: pix_en high on clk 2, 4, 6, ... after reset release; HCounter=1 after the first pix_en; HCounter wraps 799->0 and VCounter becomes 1 after 1600 clks.
- Free run: hsync low for exactly 192 clks per line; vsync low for exactly 2 lines (3200 clks); periods 1600 clks per line and 840000 clks per frame.
- frame_tick: exactly one one-clk pulse per 840000 clks, coincident with the first clk of HCounter=0, VCounter=0; no pulse on reset.
- display_on: first rises at H=144, V=35; falls at H=784 and after V=514; pixel_in=1 held at H=100, V=200 gives rgb=0, at H=300, V=200 gives rgb=3'b111.
- Reset asserted at H=400, V=300 for 3 clks: counters read 0/0 on the next edge and hsync=vsync=0; the normal sequence resumes from 0.
- With VGA_BORDER_EN and pixel_in=0: rgb=3'b111 at (144,200), (783,200), (400,35) and (400,514); rgb=0 at (145,200).
